// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    localparam int unsigned MD_DIV_ITERS = 32;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDiv,
        StFix
    } md_state_e;

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Decode/control <-> muldiv sequencer request and result signals.
interface muldiv_ctrl_if;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        rd_hi_req;
    logic        rd_lo_req;
    logic        op_ready;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;

    modport master (
        output op_valid, op, src_a, src_b, flush, rd_hi_req, rd_lo_req,
        input  op_ready, busy, stall, hi, lo, div_by_zero
    );

    modport slave (
        input  op_valid, op, src_a, src_b, flush, rd_hi_req, rd_lo_req,
        output op_ready, busy, stall, hi, lo, div_by_zero
    );
endinterface

// File: rtl/muldiv_div_core.sv
// Iterative radix-2 restoring unsigned divider: one quotient bit per step.
module muldiv_div_core (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    logic [32:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dvs_q;
    logic [32:0] rem_shift;
    logic [32:0] trial;

    // rem_q[32] is always 0 between steps, so dropping it in the shift is lossless.
    assign rem_shift = 33'({rem_q, quo_q[31]});
    assign trial     = rem_shift - {1'b0, dvs_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else if (start) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
        end else if (step) begin
            if (!trial[32]) begin
                rem_q <= trial;
                quo_q <= {quo_q[30:0], 1'b1};
            end else begin
                rem_q <= rem_shift;
                quo_q <= {quo_q[30:0], 1'b0};
            end
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q[31:0];

endmodule

// File: rtl/muldiv_ctrl.sv
// MIPS HI/LO sequencer: multi-cycle MULT/DIV, MTHI/MTLO and pipeline stall generation.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_ITERS  = MD_DIV_ITERS
) (
    input logic          clk,
    input logic          rst_n,
    muldiv_ctrl_if.slave bus
);

    localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 1);
    localparam logic [5:0] DIV_LOAD = 6'(DIV_ITERS - 1);

    md_state_e   state_q, state_d;
    logic [5:0]  cnt_q;
    logic [63:0] prod_q;
    logic        q_neg_q, r_neg_q;
    logic [31:0] hi_q, lo_q;
    logic        dbz_q;

    logic        op_ready_w, busy_w, stall_w, accept;
    logic        mul_done, div_step, fix_done, cnt_dec;
    logic        op_is_div, div_signed, mul_signed, b_zero, div_start;
    logic [63:0] a_ext, b_ext;
    logic [31:0] a_abs, b_abs, quotient, remainder, q_fix, r_fix;

    assign op_is_div  = (bus.op == MD_DIV) || (bus.op == MD_DIVU);
    assign div_signed = (bus.op == MD_DIV);
    assign mul_signed = (bus.op == MD_MULT);
    assign b_zero     = (bus.src_b == 32'd0);
    assign div_start  = accept && op_is_div && !b_zero;

    // Sign-extending to 64 bits lets one unsigned multiply serve both MULT and MULTU.
    assign a_ext = {{32{mul_signed & bus.src_a[31]}}, bus.src_a};
    assign b_ext = {{32{mul_signed & bus.src_b[31]}}, bus.src_b};
    assign a_abs = (div_signed && bus.src_a[31]) ? -bus.src_a : bus.src_a;
    assign b_abs = (div_signed && bus.src_b[31]) ? -bus.src_b : bus.src_b;
    assign q_fix = q_neg_q ? -quotient : quotient;
    assign r_fix = r_neg_q ? -remainder : remainder;

    muldiv_div_core u_div_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (div_start),
        .step      (div_step),
        .dividend  (a_abs),
        .divisor   (b_abs),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.op_valid) begin
                        case (bus.op)
                            MD_MULT, MD_MULTU: state_d = StMul;
                            MD_DIV, MD_DIVU:   state_d = b_zero ? StIdle : StDiv;
                            default:           state_d = StIdle;
                        endcase
                    end
                end
                StMul:   if (cnt_q == 6'd0) state_d = StIdle;
                StDiv:   if (cnt_q == 6'd0) state_d = StFix;
                StFix:   state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        op_ready_w = (state_q == StIdle) && !bus.flush;
        busy_w     = (state_q != StIdle);
        stall_w    = busy_w && (bus.op_valid || bus.rd_hi_req || bus.rd_lo_req);
        accept     = bus.op_valid && op_ready_w;
        mul_done   = (state_q == StMul) && (cnt_q == 6'd0) && !bus.flush;
        div_step   = (state_q == StDiv) && !bus.flush;
        fix_done   = (state_q == StFix) && !bus.flush;
        cnt_dec    = ((state_q == StMul) || (state_q == StDiv)) && (cnt_q != 6'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            prod_q  <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            dbz_q   <= 1'b0;
        end else begin
            dbz_q <= 1'b0;
            if (accept) begin
                case (bus.op)
                    MD_MULT, MD_MULTU: begin
                        prod_q <= a_ext * b_ext;
                        cnt_q  <= MUL_LOAD;
                    end
                    MD_DIV, MD_DIVU: begin
                        if (b_zero) begin
                            hi_q  <= bus.src_a;
                            lo_q  <= 32'hFFFF_FFFF;
                            dbz_q <= 1'b1;
                        end else begin
                            q_neg_q <= div_signed && (bus.src_a[31] ^ bus.src_b[31]);
                            r_neg_q <= div_signed && bus.src_a[31];
                            cnt_q   <= DIV_LOAD;
                        end
                    end
                    MD_MTHI: hi_q <= bus.src_a;
                    MD_MTLO: lo_q <= bus.src_a;
                    default: ;
                endcase
            end else if (bus.flush) begin
                cnt_q <= '0;
            end else begin
                if (mul_done) begin
                    {hi_q, lo_q} <= prod_q;
                end
                if (fix_done) begin
                    hi_q <= r_fix;
                    lo_q <= q_fix;
                end
                if (cnt_dec) begin
                    cnt_q <= cnt_q - 6'd1;
                end
            end
        end
    end

    assign bus.op_ready    = op_ready_w;
    assign bus.busy        = busy_w;
    assign bus.stall       = stall_w;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed table, random ops vs. arithmetic model, corners.
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    localparam int MUL_CYC = 4;
    localparam int DIV_LAT = 33;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    muldiv_ctrl_if bus ();

    muldiv_ctrl #(
        .MUL_CYCLES (MUL_CYC),
        .DIV_ITERS  (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          lat;
    } vec_t;

    vec_t vecs[10];
    int   pass_cnt = 0;
    int   total = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Presents one op for a cycle, then counts clock edges until busy drops.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic dbz_first);
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.op       = op;
        bus.src_a    = a;
        bus.src_b    = b;
        @(negedge clk);
        bus.op_valid = 1'b0;
        dbz_first    = bus.div_by_zero;
        lat          = 0;
        while (bus.busy && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Architectural result computed straight from the instruction definitions.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         inout logic [31:0] hi, inout logic [31:0] lo,
                         output logic dbz, output int lat);
        longint      p;
        logic [63:0] pu;
        int          sa, sb;
        dbz = 1'b0;
        lat = 0;
        case (op)
            3'd0: begin
                p = longint'($signed(a)) * longint'($signed(b));
                {hi, lo} = p;
                lat = MUL_CYC;
            end
            3'd1: begin
                pu = {32'b0, a} * {32'b0, b};
                {hi, lo} = pu;
                lat = MUL_CYC;
            end
            3'd2, 3'd3: begin
                if (b == 32'd0) begin
                    hi = a;
                    lo = 32'hFFFF_FFFF;
                    dbz = 1'b1;
                end else if (op == 3'd2) begin
                    lat = DIV_LAT;
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        lo = 32'h8000_0000;
                        hi = 32'd0;
                    end else begin
                        sa = a;
                        sb = b;
                        lo = sa / sb;
                        hi = sa % sb;
                    end
                end else begin
                    lat = DIV_LAT;
                    lo = a / b;
                    hi = a % b;
                end
            end
            3'd4: hi = a;
            3'd5: lo = a;
            default: ;
        endcase
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int          lat, n, bad;
        logic        dbz;
        logic [31:0] mhi, mlo, a, b;
        logic        mdbz;
        int          mlat;
        logic [2:0]  op;

        vecs[0] = '{MD_MTHI,  32'h1234_5678, 32'd0, 32'h1234_5678, 32'h0, 1'b0, 0};
        vecs[1] = '{MD_MULT,  32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, MUL_CYC};
        vecs[2] = '{MD_MULTU, 32'hFFFF_FFFD, 32'd7, 32'h0000_0006, 32'hFFFF_FFEB, 1'b0, MUL_CYC};
        vecs[3] = '{MD_DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, DIV_LAT};
        vecs[4] = '{MD_DIVU,  32'd7, 32'd2, 32'd1, 32'd3, 1'b0, DIV_LAT};
        vecs[5] = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, DIV_LAT};
        vecs[6] = '{MD_DIVU,  32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 0};
        vecs[7] = '{MD_MTLO,  32'hDEAD_BEEF, 32'd0, 32'd5, 32'hDEAD_BEEF, 1'b0, 0};
        vecs[8] = '{3'd6,     32'h1111_1111, 32'd3, 32'd5, 32'hDEAD_BEEF, 1'b0, 0};
        vecs[9] = '{MD_DIV,   32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, DIV_LAT};

        bus.op_valid  = 1'b0;
        bus.op        = 3'd0;
        bus.src_a     = '0;
        bus.src_b     = '0;
        bus.flush     = 1'b0;
        bus.rd_hi_req = 1'b1;
        bus.rd_lo_req = 1'b0;

        repeat (2) @(negedge clk);
        check("reset_hi", bus.hi, 0);
        check("reset_lo", bus.lo, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_stall", bus.stall, 0);
        check("reset_dbz", bus.div_by_zero, 0);
        check("reset_op_ready", bus.op_ready, 1);
        bus.rd_hi_req = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, lat, dbz);
            check($sformatf("vec%0d_hi", i), bus.hi, vecs[i].hi);
            check($sformatf("vec%0d_lo", i), bus.lo, vecs[i].lo);
            check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
            check($sformatf("vec%0d_dbz", i), dbz, vecs[i].dbz);
            @(negedge clk);
            check($sformatf("vec%0d_dbz_end", i), bus.div_by_zero, 0);
        end

        mhi = bus.hi;
        mlo = bus.lo;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = $urandom_range(1, 5);
                3: a = $urandom_range(0, 20);
                default: ;
            endcase
            model(op, a, b, mhi, mlo, mdbz, mlat);
            issue(op, a, b, lat, dbz);
            check($sformatf("rnd%0d_op%0d_hi", i, op), bus.hi, mhi);
            check($sformatf("rnd%0d_op%0d_lo", i, op), bus.lo, mlo);
            check($sformatf("rnd%0d_op%0d_lat", i, op), lat, mlat);
            check($sformatf("rnd%0d_op%0d_dbz", i, op), dbz, mdbz);
        end

        // Held request and MFHI during a divide: stall every busy cycle, accept when idle.
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.op = MD_DIV;
        bus.src_a = 32'd100;
        bus.src_b = 32'd7;
        @(negedge clk);
        bus.op = MD_MTLO;
        bus.src_a = 32'h55;
        bus.rd_hi_req = 1'b1;
        bad = 0;
        n = 0;
        while (bus.busy && n < 100) begin
            if (!bus.stall || bus.op_ready) bad++;
            n++;
            @(negedge clk);
        end
        check("stall_every_busy_cycle", bad, 0);
        check("stall_busy_cycles", n, DIV_LAT);
        check("idle_op_ready", bus.op_ready, 1);
        check("idle_no_stall", bus.stall, 0);
        @(negedge clk);
        bus.op_valid = 1'b0;
        bus.rd_hi_req = 1'b0;
        check("queued_op_lo", bus.lo, 32'h55);
        check("queued_div_hi", bus.hi, 32'd2);

        // Flush on the tenth divide cycle leaves HI/LO untouched.
        issue(MD_MTHI, 32'hAAAA_AAAA, 32'd0, lat, dbz);
        issue(MD_MTLO, 32'hAAAA_AAAA, 32'd0, lat, dbz);
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.op = MD_DIV;
        bus.src_a = 32'd1000;
        bus.src_b = 32'd3;
        @(negedge clk);
        bus.op_valid = 1'b0;
        repeat (9) @(negedge clk);
        check("flush_pre_busy", bus.busy, 1);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_busy", bus.busy, 0);
        check("flush_hi", bus.hi, 32'hAAAA_AAAA);
        check("flush_lo", bus.lo, 32'hAAAA_AAAA);
        bus.op_valid = 1'b1;
        bus.op = MD_MTHI;
        bus.src_a = 32'h1234;
        bus.flush = 1'b1;
        check("flush_blocks_ready", bus.op_ready, 0);
        @(negedge clk);
        bus.op_valid = 1'b0;
        bus.flush = 1'b0;
        check("flush_blocks_accept", bus.hi, 32'hAAAA_AAAA);
        issue(MD_DIVU, 32'd9, 32'd4, lat, dbz);
        check("post_flush_lat", lat, DIV_LAT);
        check("post_flush_lo", bus.lo, 32'd2);
        check("post_flush_hi", bus.hi, 32'd1);

        // Asynchronous reset in the middle of a multiply.
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.op = MD_MULT;
        bus.src_a = 32'd3;
        bus.src_b = 32'd5;
        @(negedge clk);
        bus.op_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_rst_hi", bus.hi, 0);
        check("async_rst_lo", bus.lo, 0);
        check("async_rst_busy", bus.busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(MD_MULT, 32'd3, 32'd5, lat, dbz);
        check("post_rst_lat", lat, MUL_CYC);
        check("post_rst_lo", bus.lo, 32'd15);
        check("post_rst_hi", bus.hi, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
